// File: rtl/filtro_mac_pkg.sv
// Shared definitions for the FILTRO MAC stage: FSM encodings and width helpers.
package filtro_mac_pkg;

  // 3-bit FSM encodings
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEER = 3'd1;
  localparam logic [2:0] S_MAC0 = 3'd2;
  localparam logic [2:0] S_MAC1 = 3'd3;
  localparam logic [2:0] S_MAC2 = 3'd4;
  localparam logic [2:0] S_RND  = 3'd5;
  localparam logic [2:0] S_DESP = 3'd6;

  // Accumulator width: full product plus two guard bits for the three-term sum
  function automatic int acc_width(input int cant_bits);
    return 2 * cant_bits + 2;
  endfunction

endpackage

// File: rtl/filtro_sat_rnd.sv
// Combinational round-half-up and saturation from accumulator to output Q format.
module filtro_sat_rnd
  import filtro_mac_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int frac_bits = 16,
  parameter int acc_w     = acc_width(cant_bits)
) (
  input  logic signed [acc_w-1:0]     acc,
  output logic        [cant_bits-1:0] y,
  output logic                        sat
);

  // Half an LSB of the output, in accumulator units
  localparam logic signed [acc_w-1:0] RND_K =
    {{(acc_w-1){1'b0}}, 1'b1} << (frac_bits - 1);
  localparam logic signed [acc_w-1:0] Y_MAX =
    {{(acc_w-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
  localparam logic signed [acc_w-1:0] Y_MIN =
    {{(acc_w-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

  logic signed [acc_w-1:0] sum;
  logic signed [acc_w-1:0] r;

  // Round, arithmetic shift down to output scale, then clip to the output range
  always_comb begin
    sum = acc + RND_K;
    r   = sum >>> frac_bits;
    y   = r[cant_bits-1:0];
    sat = 1'b0;
    if (r > Y_MAX) begin
      y   = Y_MAX[cant_bits-1:0];
      sat = 1'b1;
    end else if (r < Y_MIN) begin
      y   = Y_MIN[cant_bits-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/filtro_mac.sv
// FILTRO 2nd-order FIR stage: one shared multiplier over three cycles, then round/saturate.
//
//  state | meaning
//  IDLE  | waiting for start
//  LEER  | leer=1, memory captures new x0 on the closing edge
//  MAC0  | acc = b0*x0
//  MAC1  | acc += b1*x1
//  MAC2  | acc += b2*x2
//  RND   | y/sat registered from rounded, saturated acc
//  DESP  | desp=1, y_valid=1, memory shifts taps
module filtro_mac
  import filtro_mac_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int frac_bits = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [cant_bits-1:0] b0,
  input  logic [cant_bits-1:0] b1,
  input  logic [cant_bits-1:0] b2,
  input  logic [cant_bits-1:0] x0,
  input  logic [cant_bits-1:0] x1,
  input  logic [cant_bits-1:0] x2,
  output logic                 leer,
  output logic                 desp,
  output logic [cant_bits-1:0] y,
  output logic                 y_valid,
  output logic                 sat,
  output logic                 busy
);

  localparam int ACC_W = acc_width(cant_bits);
  localparam int PRD_W = 2 * cant_bits;

  logic [2:0]               state, state_n;
  logic signed [ACC_W-1:0]  acc;
  logic signed [cant_bits-1:0] op_b, op_x;
  logic signed [PRD_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [cant_bits-1:0]     y_n;
  logic                     sat_n;

  // Next-state decode: linear sequence, start only honoured in IDLE
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LEER;
      S_LEER:  state_n = S_MAC0;
      S_MAC0:  state_n = S_MAC1;
      S_MAC1:  state_n = S_MAC2;
      S_MAC2:  state_n = S_RND;
      S_RND:   state_n = S_DESP;
      S_DESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Operand mux feeding the single shared multiplier
  always_comb begin
    op_b = '0;
    op_x = '0;
    case (state)
      S_MAC0: begin op_b = signed'(b0); op_x = signed'(x0); end
      S_MAC1: begin op_b = signed'(b1); op_x = signed'(x1); end
      S_MAC2: begin op_b = signed'(b2); op_x = signed'(x2); end
      default: ;
    endcase
  end

  assign prod     = op_b * op_x;
  assign prod_ext = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};

  // Accumulator: load on the first tap, add on the next two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  acc <= '0;
    else if (state == S_MAC0)                    acc <= prod_ext;
    else if (state == S_MAC1 || state == S_MAC2) acc <= acc + prod_ext;
  end

  filtro_sat_rnd #(
    .cant_bits (cant_bits),
    .frac_bits (frac_bits),
    .acc_w     (ACC_W)
  ) u_sat_rnd (
    .acc (acc),
    .y   (y_n),
    .sat (sat_n)
  );

  // Result register, updated only at the end of RND and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (state == S_RND) begin
      y   <= y_n;
      sat <= sat_n;
    end
  end

  assign leer    = (state == S_LEER);
  assign desp    = (state == S_DESP);
  assign y_valid = (state == S_DESP);
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_filtro_mac.sv
// Self-checking bench for filtro_mac: directed vector table, corner sequences, random vs model.
module tb_filtro_mac;

  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] b0, b1, b2, x0, x1, x2;
  logic         leer, desp, y_valid, sat, busy;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;

  filtro_mac #(.cant_bits(W), .frac_bits(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .b0(b0), .b1(b1), .b2(b2), .x0(x0), .x1(x1), .x2(x2),
    .leer(leer), .desp(desp), .y(y), .y_valid(y_valid), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] c0, c1, c2, t0, t1, t2;
    logic [W-1:0] exp_y;
    logic         exp_sat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer FIR with round-half-up and clipping
  function automatic void model(input logic [W-1:0] c0, c1, c2, t0, t1, t2,
                                output logic [W-1:0] ry, output logic rs);
    longint s, r;
    longint vmax, vmin;
    vmax = (longint'(1) << (W-1)) - 1;
    vmin = -(longint'(1) << (W-1));
    s = longint'($signed(c0)) * longint'($signed(t0))
      + longint'($signed(c1)) * longint'($signed(t1))
      + longint'($signed(c2)) * longint'($signed(t2));
    r = (s + 32768) >>> 16;
    rs = 1'b0;
    if (r > vmax) begin r = vmax; rs = 1'b1; end
    else if (r < vmin) begin r = vmin; rs = 1'b1; end
    ry = r[W-1:0];
  endfunction

  // Runs one sample from a negedge; observes cycles 1..9 after the start edge.
  // poke: cycle in which start is re-pulsed (0 = never).
  task automatic run_sample(input string tag,
                            input logic [W-1:0] c0, c1, c2, t0, t1, t2,
                            input int poke,
                            output logic [W-1:0] got_y, output logic got_sat);
    logic [9:0] m_leer, m_desp, m_valid, m_busy;
    logic [W-1:0] y_cap;
    int overlap;
    m_leer = '0; m_desp = '0; m_valid = '0; m_busy = '0;
    overlap = 0; y_cap = '0;
    got_y = '0; got_sat = 1'b0;
    b0 = c0; b1 = c1; b2 = c2; x0 = t0; x1 = t1; x2 = t2;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = (i == poke);
      m_leer[i]  = leer;
      m_desp[i]  = desp;
      m_valid[i] = y_valid;
      m_busy[i]  = busy;
      if (leer && desp) overlap++;
      if (y_valid) begin
        got_y = y; got_sat = sat; y_cap = y;
      end
    end
    start = 1'b0;
    chk({tag, " y_valid_cycle6"}, 64'(m_valid), 64'(10'b0001000000));
    chk({tag, " leer_pulse"},     64'(m_leer),  64'(10'b0000000010));
    chk({tag, " desp_pulse"},     64'(m_desp),  64'(10'b0001000000));
    chk({tag, " busy_window"},    64'(m_busy),  64'(10'b0001111110));
    chk({tag, " no_overlap"},     64'(overlap), 64'(0));
    chk({tag, " y_hold"},         64'(y),       64'(y_cap));
  endtask

  logic [W-1:0] gy, my;
  logic         gs, ms;
  int           cnt_v, cnt_d;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    b0 = '0; b1 = '0; b2 = '0; x0 = '0; x1 = '0; x2 = '0;

    vecs[0] = '{25'd65536, 25'd0, 25'd0, 25'd196608, 25'd196608, 25'd196608, 25'd196608, 1'b0};
    vecs[1] = '{25'd21845, 25'd21845, 25'd21845, 25'd98304, 25'd98304, 25'd98304, 25'h17FFF, 1'b0};
    vecs[2] = '{25'd32768, 25'd0, 25'd0, 25'd1, 25'd0, 25'd0, 25'd1, 1'b0};
    vecs[3] = '{25'd32768, 25'd0, 25'd0, 25'h1FFFFFF, 25'd0, 25'd0, 25'd0, 1'b0};
    vecs[4] = '{25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 1'b1};
    vecs[5] = '{25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000, 1'b1};
    vecs[6] = '{25'h1FF0000, 25'd0, 25'd65536, 25'd131072, 25'd7, 25'h1FE0000, 25'h1FC0000, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset y",      64'(y), 64'(0));
    chk("reset sat",    64'(sat), 64'(0));
    chk("reset strobes", 64'({leer, desp, y_valid, busy}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int k = 0; k < 7; k++) begin
      run_sample($sformatf("vec%0d", k), vecs[k].c0, vecs[k].c1, vecs[k].c2,
                 vecs[k].t0, vecs[k].t1, vecs[k].t2, 0, gy, gs);
      chk($sformatf("vec%0d y", k),   64'(gy), 64'(vecs[k].exp_y));
      chk($sformatf("vec%0d sat", k), 64'(gs), 64'(vecs[k].exp_sat));
    end

    // start re-pulsed during MAC1 must be ignored and not queued
    run_sample("busy", 25'd65536, 25'd65536, 25'd0, 25'd100, 25'd200, 25'd0, 3, gy, gs);
    chk("busy y", 64'(gy), 64'(300));
    run_sample("after_busy", 25'd65536, 25'd0, 25'd0, 25'd1234, 25'd0, 25'd0, 0, gy, gs);
    chk("after_busy y", 64'(gy), 64'(1234));

    // Reset asserted during MAC2
    b0 = 25'd65536; b1 = '0; b2 = '0; x0 = 25'd999; x1 = '0; x2 = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst y",    64'(y), 64'(0));
    chk("midrst outs", 64'({leer, desp, y_valid, sat}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    cnt_v = 0; cnt_d = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (y_valid) cnt_v++;
      if (desp) cnt_d++;
    end
    chk("midrst no y_valid", 64'(cnt_v), 64'(0));
    chk("midrst no desp",    64'(cnt_d), 64'(0));
    run_sample("after_rst", 25'd65536, 25'd0, 25'd0, 25'd999, 25'd0, 25'd0, 0, gy, gs);
    chk("after_rst y", 64'(gy), 64'(999));

    // Random stimulus against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] r[6];
      for (int j = 0; j < 6; j++) begin
        if (n % 2 == 0) r[j] = W'($urandom());
        else            r[j] = W'(int'($urandom_range(0, 262143)) - 131072);
      end
      model(r[0], r[1], r[2], r[3], r[4], r[5], my, ms);
      run_sample($sformatf("rnd%0d", n), r[0], r[1], r[2], r[3], r[4], r[5], 0, gy, gs);
      chk($sformatf("rnd%0d y", n),   64'(gy), 64'(my));
      chk($sformatf("rnd%0d sat", n), 64'(gs), 64'(ms));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
